ro_delta_monitor: RTL
=====================

Name: ro_delta_monitor

Overview:
- Consumes the free-running 32-bit ring-oscillator count exported by nios2_b_ring_oscillator_0 (system top-level export) and turns it into per-window frequency samples (count deltas).
- Buffers samples in a small FIFO for a downstream reader and tracks running min/max.
- Raises a sticky alarm when a delta leaves a programmed band. This supports RO-based power/activity monitoring while the AES core runs.

Parameters:
- WINDOW_CYCLES, 50000, clk_clk cycles per measurement window (≥2).
- FIFO_DEPTH, 8, sample FIFO entries (power of 2, ≥2).
- LVL_W, 4, width of fifo_level (= log2(FIFO_DEPTH)+1).

Ports:
- clk_clk  in  1  system clock; single clock domain.
- reset_reset_n  in  1  synchronous, active-low reset.
- ro_count  in  32  RO counter value, registered in the clk_clk domain by the RO peripheral.
- enable  in  1  level; 1 = measure.
- clear_stats  in  1  one-cycle pulse; re-initialises min/max and clears alarm/overflow.
- thresh_lo  in  32  lower alarm bound (inclusive-valid).
- thresh_hi  in  32  upper alarm bound (inclusive-valid).
- sample_data  out  32  FIFO head delta.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  reader pop; a pop occurs when sample_valid && sample_ready.
- fifo_level  out  LVL_W  entries held.
- overflow  out  1  sticky; a sample was dropped.
- min_delta  out  32  smallest delta since reset/clear.
- max_delta  out  32  largest delta since reset/clear.
- alarm  out  1  sticky out-of-band flag.

Behaviour:
- Reset (reset_reset_n=0 at a rising edge):
  - state=IDLE, window counter=0, prev=0, FIFO empty.
  - sample_data=0, sample_valid=0, fifo_level=0, overflow=0, alarm=0.
  - min_delta=32'hFFFFFFFF, max_delta=0.
  - Reset mid-window discards any partial window and any in-flight delta.
- FSM states:
  - IDLE: window counter held at 0. enable=1 → PRIME.
  - PRIME: counter runs 0..WINDOW_CYCLES-1. At terminal count, latch prev<=ro_count, emit nothing, go to RUN.
  - RUN: at each terminal count, latch prev<=ro_count and compute delta=ro_count-prev modulo 2^32. Counter wrap (ro_count<prev) therefore yields the correct positive delta.
  - enable=0 in any state → IDLE next cycle and window counter cleared. An in-flight delta already registered still completes. FIFO contents and statistics are retained.
- Timing (terminal-count cycle = T):
  - ro_count is sampled in cycle T.
  - delta register is valid at T+1.
  - At T+2 the FIFO entry is visible, and min/max/alarm are updated.
  - With FIFO previously empty, sample_valid rises at T+2 (no fall-through bypass).
- Statistics:
  - Every RUN delta updates min/max and is checked against the band, whether or not the FIFO accepts it.
  - Out-of-band means delta < thresh_lo or delta > thresh_hi; this sets alarm=1 (sticky).
  - If thresh_lo > thresh_hi, every delta alarms.
- clear_stats:
  - Sets min=FFFFFFFF, max=0, alarm=0, overflow=0 at the next edge.
  - If a delta update lands on the same edge, that delta becomes both min and max, and its alarm/overflow result is applied (update wins over clear).
  - FIFO contents are unaffected.
- FIFO behaviour:
  - Push is accepted when not full, or when full and a pop occurs in the same cycle (level unchanged).
  - A push while full with no pop drops the new sample (oldest data preserved) and sets overflow=1.
  - A pop while empty is ignored.
  - Simultaneous push and pop leaves the level unchanged and sample_data advances.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - sample_data holds its value while not popped and is 0 when empty.

Test Plan:
- WINDOW_CYCLES=4; reset; enable=1; ro_count ramps +10/cycle → first sample_valid 2 cycles after the second terminal count, sample_data=40; min=max=40; no entry from the PRIME window.
- At terminal counts, ro_count goes FFFFFFF0 then 00000010 → delta=0x20, no alarm with thresh_lo=0, thresh_hi=0x100.
- sample_ready=0 for 10 windows, FIFO_DEPTH=8 → fifo_level=8, overflow=1. Draining yields the first 8 deltas in order; the 9th and 10th are lost.
- thresh_lo=30, thresh_hi=50; deltas 40, 60, 40 → alarm rises at T+2 of the 60 window and stays 1. clear_stats → alarm=0, min=FFFFFFFF, max=0.
- clear_stats pulsed on the same edge as delta=25 is recorded → min=max=25; with thresh_lo=30, alarm=1.
- enable dropped mid-window, then re-asserted → a fresh PRIME window with no sample. Reset asserted mid-window → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ro_delta_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ro_delta_monitor
// Description : Converts a free-running 32-bit ring-oscillator count into
//               per-window frequency samples. A sample is the count delta
//               across one measurement window. Samples are queued in a small
//               FIFO, tracked for running min/max, and checked against a
//               programmable band that raises a sticky alarm.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_clk        in   system clock (single domain)
//   reset_reset_n  in   synchronous active-low reset
//   ro_count       in   32-bit RO counter value (already in clk_clk domain)
//   enable         in   level, 1 = measure
//   clear_stats    in   pulse, re-initialise min/max, clear alarm/overflow
//   thresh_lo/hi   in   inclusive alarm band
//   sample_data    out  FIFO head delta (0 when empty)
//   sample_valid   out  FIFO non-empty
//   sample_ready   in   reader pop strobe
//   fifo_level     out  entries held
//   overflow       out  sticky, a sample was dropped
//   min_delta      out  smallest delta since reset/clear
//   max_delta      out  largest delta since reset/clear
//   alarm          out  sticky out-of-band flag
// ============================================================================
module ro_delta_monitor #(
  parameter int WINDOW_CYCLES = 50000,
  parameter int FIFO_DEPTH    = 8,
  parameter int LVL_W         = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [31:0]      ro_count,
  input  logic             enable,
  input  logic             clear_stats,
  input  logic [31:0]      thresh_lo,
  input  logic [31:0]      thresh_hi,
  output logic [31:0]      sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic [31:0]      min_delta,
  output logic [31:0]      max_delta,
  output logic             alarm
);

  localparam int                CNT_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        prev_q, prev_d;
  logic [31:0]        delta_q, delta_d;
  logic               dvld_q, dvld_d;

  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [LVL_W-1:0]   level_q, level_d;

  logic [31:0]        min_q, min_d;
  logic [31:0]        max_q, max_d;
  logic               alarm_q, alarm_d;
  logic               ovf_q, ovf_d;

  logic               terminal;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic [31:0]        min_base;
  logic [31:0]        max_base;

  // Window sequencer. The PRIME window only establishes the reference count,
  // so the first delta comes out of the first RUN window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    delta_d  = delta_q;
    dvld_d   = 1'b0;
    terminal = (cnt_q == CNT_LAST);

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
          cnt_d   = '0;
        end
        ST_PRIME: begin
          if (terminal) begin
            prev_d  = ro_count;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (terminal) begin
            prev_d  = ro_count;
            // Modulo-2^32 subtraction gives the right delta across counter wrap.
            delta_d = ro_count - prev_q;
            dvld_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FIFO control. A full FIFO still accepts a push when the same cycle pops.
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_FULL);
    pop        = sample_ready && !fifo_empty;
    push_ok    = dvld_q && (!fifo_full || pop);
    drop       = dvld_q && fifo_full && !pop;

    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop     ? rd_q + 1'b1 : rd_q;
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // Statistics. A delta landing on the same edge as clear_stats is applied on
  // top of the cleared values, so the update wins.
  always_comb begin
    min_base = clear_stats ? 32'hFFFF_FFFF : min_q;
    max_base = clear_stats ? 32'h0000_0000 : max_q;
    min_d    = min_base;
    max_d    = max_base;
    alarm_d  = clear_stats ? 1'b0 : alarm_q;
    ovf_d    = (clear_stats ? 1'b0 : ovf_q) | drop;
    if (dvld_q) begin
      if (delta_q < min_base) min_d = delta_q;
      if (delta_q > max_base) max_d = delta_q;
      if ((delta_q < thresh_lo) || (delta_q > thresh_hi)) alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
      delta_q <= '0;
      dvld_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      min_q   <= 32'hFFFF_FFFF;
      max_q   <= '0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      delta_q <= delta_d;
      dvld_q  <= dvld_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      min_q   <= min_d;
      max_q   <= max_d;
      alarm_q <= alarm_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array is written in place; its contents are only observable
  // through the level-gated head read, so it carries no reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n && push_ok) begin
      mem_q[wr_q] <= delta_q;
    end
  end

  assign sample_data  = fifo_empty ? 32'h0 : mem_q[rd_q];
  assign sample_valid = !fifo_empty;
  assign fifo_level   = level_q;
  assign overflow     = ovf_q;
  assign min_delta    = min_q;
  assign max_delta    = max_q;
  assign alarm        = alarm_q;

endmodule
`default_nettype wire
